outbound_fifo_ctrl: RTL and testbench

OUTBOUND_FIFO_CTRL -- requirements
Module: outbound_fifo_ctrl

---
 rtl/outbound_fifo_pkg.sv | 17 +
 rtl/outbound_fifo_ctrl.sv | 149 ++++++++++++++
 tb/tb_outbound_fifo_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/outbound_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : outbound_fifo_pkg
//  Description : Default sizing and threshold constants shared by the
//                outbound FIFO controller and its integrators.
//  Revision    : 1.0 - initial release
// ============================================================================
package outbound_fifo_pkg;

    localparam int c_width     = 32;   // data width
    localparam int c_addr_w    = 7;    // RAM address width, depth = 128
    localparam int c_rd_lat    = 1;    // RAM read latency (1 or 2)
    localparam int c_afull_th  = 120;  // almost-full when count >= this
    localparam int c_aempty_th = 8;    // almost-empty when count <= this

endpackage : outbound_fifo_pkg
`default_nettype wire

// File: rtl/outbound_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : outbound_fifo_ctrl
//  Description : Pointer/flag controller for a FIFO built around an external
//                simple dual-port RAM. Writes and reads are accepted the same
//                cycle they are requested (RAM ports driven combinationally);
//                all status flags are registered from the next-state count.
//  Revision    : 1.0 - initial release
//
//  Ports
//    CLOCK, RESET_N          : clock, asynchronous active-low reset
//    WE, DATA                : user write request and data
//    RE                      : user read request
//    Q, DVLD                 : read data and its valid strobe (RD_LAT later)
//    FULL, EMPTY             : occupancy == depth / occupancy == 0
//    AFULL, AEMPTY           : occupancy >= AFULL_TH / occupancy <= AEMPTY_TH
//    OVERFLOW, UNDERFLOW     : one-cycle pulse after a rejected write / read
//    WRCNT                   : registered occupancy, 0..2**ADDR_W
//    MEM_WDATA/WADDR/WEN     : RAM write port
//    MEM_RADDR/REN/RDATA     : RAM read port
// ============================================================================
module outbound_fifo_ctrl
    import outbound_fifo_pkg::*;
#(
    parameter int WIDTH     = c_width,
    parameter int ADDR_W    = c_addr_w,
    parameter int RD_LAT    = c_rd_lat,
    parameter int AFULL_TH  = c_afull_th,
    parameter int AEMPTY_TH = c_aempty_th
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              WE,
    input  logic [WIDTH-1:0]  DATA,
    input  logic              RE,
    output logic [WIDTH-1:0]  Q,
    output logic              DVLD,
    output logic              FULL,
    output logic              EMPTY,
    output logic              AFULL,
    output logic              AEMPTY,
    output logic              OVERFLOW,
    output logic              UNDERFLOW,
    output logic [ADDR_W:0]   WRCNT,
    output logic [WIDTH-1:0]  MEM_WDATA,
    output logic [ADDR_W-1:0] MEM_WADDR,
    output logic              MEM_WEN,
    output logic [ADDR_W-1:0] MEM_RADDR,
    output logic              MEM_REN,
    input  logic [WIDTH-1:0]  MEM_RDATA
);

    localparam logic [ADDR_W:0] c_depth     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_afull_lvl = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] c_aempt_lvl = AEMPTY_TH[ADDR_W:0];

    logic [ADDR_W:0]   r_wptr;
    logic [ADDR_W:0]   r_rptr;
    logic [ADDR_W:0]   r_cnt;
    logic              r_full;
    logic              r_empty;
    logic              r_afull;
    logic              r_aempty;
    logic              r_ovf;
    logic              r_udf;
    logic [RD_LAT-1:0] r_dvld_sr;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [ADDR_W:0]   w_wptr_nxt;
    logic [ADDR_W:0]   w_rptr_nxt;
    logic [ADDR_W:0]   w_cnt_nxt;

    // Acceptance uses the registered flags only, so a read can never target
    // the slot being written in the same cycle.
    assign w_wr_acc = WE & ~r_full;
    assign w_rd_acc = RE & ~r_empty;

    assign w_wptr_nxt = r_wptr + {{ADDR_W{1'b0}}, w_wr_acc};
    assign w_rptr_nxt = r_rptr + {{ADDR_W{1'b0}}, w_rd_acc};

    // The extra pointer MSB makes the modular difference span 0..depth, so
    // this equals the running +1/-1 count without a separate adder path.
    assign w_cnt_nxt  = w_wptr_nxt - w_rptr_nxt;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_wptr   <= w_wptr_nxt;
            r_rptr   <= w_rptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_full   <= (w_cnt_nxt == c_depth);
            r_empty  <= (w_cnt_nxt == '0);
            r_afull  <= (w_cnt_nxt >= c_afull_lvl);
            r_aempty <= (w_cnt_nxt <= c_aempt_lvl);
            r_ovf    <= WE & r_full;
            r_udf    <= RE & r_empty;
        end
    end

    // Read-valid pipeline matching the RAM read latency.
    generate
        if (RD_LAT == 1) begin : g_lat_one
            always_ff @(posedge CLOCK or negedge RESET_N) begin
                if (!RESET_N) begin
                    r_dvld_sr <= '0;
                end else begin
                    r_dvld_sr <= w_rd_acc;
                end
            end
        end else begin : g_lat_multi
            always_ff @(posedge CLOCK or negedge RESET_N) begin
                if (!RESET_N) begin
                    r_dvld_sr <= '0;
                end else begin
                    r_dvld_sr <= {r_dvld_sr[RD_LAT-2:0], w_rd_acc};
                end
            end
        end
    endgenerate

    assign MEM_WEN   = w_wr_acc;
    assign MEM_WADDR = r_wptr[ADDR_W-1:0];
    assign MEM_WDATA = DATA;
    assign MEM_REN   = w_rd_acc;
    assign MEM_RADDR = r_rptr[ADDR_W-1:0];

    assign DVLD      = r_dvld_sr[RD_LAT-1];
    assign Q         = DVLD ? MEM_RDATA : '0;

    assign FULL      = r_full;
    assign EMPTY     = r_empty;
    assign AFULL     = r_afull;
    assign AEMPTY    = r_aempty;
    assign OVERFLOW  = r_ovf;
    assign UNDERFLOW = r_udf;
    assign WRCNT     = r_cnt;

endmodule : outbound_fifo_ctrl
`default_nettype wire

// File: tb/tb_outbound_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_outbound_fifo_ctrl
//  Description : Self-checking bench for outbound_fifo_ctrl. Two controllers
//                (read latency 1 and 2) share one stimulus stream, each with
//                its own RAM. A queue-based FIFO model predicts every output
//                and is compared on each falling edge; directed literal
//                checks pin the model at the interesting boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_outbound_fifo_ctrl;

    logic        CLOCK = 1'b0;
    logic        RESET_N;
    logic        WE, RE;
    logic [31:0] DATA;

    // latency-1 instance
    logic [31:0] q1, wd1, rd1;
    logic [6:0]  wa1, ra1;
    logic [7:0]  cnt1;
    logic        dv1, full1, empty1, afull1, aempty1, ovf1, udf1, wen1, ren1;
    // latency-2 instance
    logic [31:0] q2, wd2, rd2, stage2;
    logic [6:0]  wa2, ra2;
    logic [7:0]  cnt2;
    logic        dv2, full2, empty2, afull2, aempty2, ovf2, udf2, wen2, ren2;

    logic [31:0] mem1 [128];
    logic [31:0] mem2 [128];

    int errors = 0;
    int checks = 0;

    always #5 CLOCK = ~CLOCK;

    outbound_fifo_ctrl #(.RD_LAT(1)) dut1 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .WE(WE), .DATA(DATA), .RE(RE),
        .Q(q1), .DVLD(dv1), .FULL(full1), .EMPTY(empty1), .AFULL(afull1),
        .AEMPTY(aempty1), .OVERFLOW(ovf1), .UNDERFLOW(udf1), .WRCNT(cnt1),
        .MEM_WDATA(wd1), .MEM_WADDR(wa1), .MEM_WEN(wen1),
        .MEM_RADDR(ra1), .MEM_REN(ren1), .MEM_RDATA(rd1)
    );

    outbound_fifo_ctrl #(.RD_LAT(2)) dut2 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .WE(WE), .DATA(DATA), .RE(RE),
        .Q(q2), .DVLD(dv2), .FULL(full2), .EMPTY(empty2), .AFULL(afull2),
        .AEMPTY(aempty2), .OVERFLOW(ovf2), .UNDERFLOW(udf2), .WRCNT(cnt2),
        .MEM_WDATA(wd2), .MEM_WADDR(wa2), .MEM_WEN(wen2),
        .MEM_RADDR(ra2), .MEM_REN(ren2), .MEM_RDATA(rd2)
    );

    // RAMs: contents untouched by reset.
    always @(posedge CLOCK) begin
        if (wen1) mem1[wa1] <= wd1;
        if (ren1) rd1 <= mem1[ra1];
        if (wen2) mem2[wa2] <= wd2;
        if (ren2) stage2 <= mem2[ra2];
        rd2 <= stage2;
    end

    // ------------------------------------------------------------------
    // Behavioural FIFO model
    // ------------------------------------------------------------------
    logic [31:0] m_q [$];
    int          m_wp = 0;
    int          m_rp = 0;
    bit          m_ovf = 0;
    bit          m_udf = 0;
    bit          sh_v [2] = '{0, 0};
    logic [31:0] sh_d [2] = '{0, 0};
    bit          m_aw, m_ar;
    logic [31:0] m_pop;

    always @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_q.delete();
            m_wp = 0; m_rp = 0; m_ovf = 0; m_udf = 0;
            sh_v[0] = 0; sh_v[1] = 0;
        end else begin
            m_aw  = WE && (m_q.size() < 128);
            m_ar  = RE && (m_q.size() > 0);
            m_ovf = WE && (m_q.size() == 128);
            m_udf = RE && (m_q.size() == 0);
            m_pop = '0;
            if (m_ar) begin
                m_pop = m_q.pop_front();
                m_rp  = (m_rp + 1) % 256;
            end
            if (m_aw) begin
                m_q.push_back(DATA);
                m_wp = (m_wp + 1) % 256;
            end
            sh_v[1] = sh_v[0]; sh_d[1] = sh_d[0];
            sh_v[0] = m_ar;    sh_d[0] = m_pop;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string t, input int lat,
                            input logic full, input logic empty,
                            input logic afull, input logic aempty,
                            input logic ovf, input logic udf,
                            input logic [7:0] cnt,
                            input logic wen, input logic [6:0] wa,
                            input logic [31:0] wd,
                            input logic ren, input logic [6:0] ra,
                            input logic dv, input logic [31:0] q);
        int  n;
        bit  ew, er;
        n  = m_q.size();
        ew = (RESET_N === 1'b1) && WE && (n < 128);
        er = (RESET_N === 1'b1) && RE && (n > 0);
        chk({t, ".FULL"},      full,   64'(n == 128));
        chk({t, ".EMPTY"},     empty,  64'(n == 0));
        chk({t, ".AFULL"},     afull,  64'(n >= 120));
        chk({t, ".AEMPTY"},    aempty, 64'(n <= 8));
        chk({t, ".OVERFLOW"},  ovf,    64'(m_ovf));
        chk({t, ".UNDERFLOW"}, udf,    64'(m_udf));
        chk({t, ".WRCNT"},     cnt,    64'(n));
        if (RESET_N === 1'b1) begin
            chk({t, ".MEM_WEN"}, wen, 64'(ew));
            chk({t, ".MEM_REN"}, ren, 64'(er));
            if (ew) begin
                chk({t, ".MEM_WADDR"}, wa, 64'(m_wp % 128));
                chk({t, ".MEM_WDATA"}, wd, 64'(DATA));
            end
            if (er) chk({t, ".MEM_RADDR"}, ra, 64'(m_rp % 128));
        end
        chk({t, ".DVLD"}, dv, 64'(sh_v[lat-1]));
        if (sh_v[lat-1]) chk({t, ".Q"}, q, 64'(sh_d[lat-1]));
    endtask

    // Drain-sequence and reset-window monitors.
    bit seq_on = 0;
    int idx1 = 0;
    int idx2 = 0;
    bit win = 0;
    bit seen2 = 0;

    always @(negedge CLOCK) begin
        cmp_inst("L1", 1, full1, empty1, afull1, aempty1, ovf1, udf1, cnt1,
                 wen1, wa1, wd1, ren1, ra1, dv1, q1);
        cmp_inst("L2", 2, full2, empty2, afull2, aempty2, ovf2, udf2, cnt2,
                 wen2, wa2, wd2, ren2, ra2, dv2, q2);
        if (seq_on && dv1) begin chk("drain_seq_L1", q1, 64'(idx1)); idx1++; end
        if (seq_on && dv2) begin chk("drain_seq_L2", q2, 64'(idx2)); idx2++; end
        if (win && dv2) seen2 = 1;
    end

    task automatic step(input logic we, input logic re, input logic [31:0] d);
        WE = we; RE = re; DATA = d;
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0; WE = 1'b0; RE = 1'b0; DATA = '0;
        repeat (2) @(posedge CLOCK);
        #1;
        chk("rst_EMPTY",  empty1, 1);
        chk("rst_AEMPTY", aempty2, 1);
        chk("rst_FULL",   full1, 0);
        chk("rst_WRCNT",  cnt2, 0);
        chk("rst_DVLD",   dv2, 0);
        RESET_N = 1'b1;
        step(0, 0, 0);

        // Fill 0..127.
        for (int i = 0; i < 128; i++) begin
            step(1, 0, 32'(i));
            if (i == 118) chk("afull_before_120", afull1, 0);
            if (i == 119) begin
                chk("afull_after_120_L1", afull1, 1);
                chk("afull_after_120_L2", afull2, 1);
            end
        end
        chk("full_after_128", full1, 1);
        chk("wrcnt_128",      cnt1, 128);

        // Write while full.
        WE = 1; RE = 0; DATA = 32'hDEAD;
        #1;
        chk("full_write_MEM_WEN", wen1, 0);
        @(posedge CLOCK); #1;
        chk("overflow_pulse", ovf1, 1);
        chk("overflow_wrcnt", cnt2, 128);
        step(0, 0, 0);
        chk("overflow_single", ovf1, 0);

        // Drain 128 words in order.
        seq_on = 1;
        for (int i = 0; i < 128; i++) step(0, 1, 0);
        chk("empty_after_drain_L1", empty1, 1);
        chk("empty_after_drain_L2", empty2, 1);
        step(0, 1, 0);
        chk("underflow_pulse", udf1, 1);
        repeat (3) step(0, 0, 0);
        seq_on = 0;
        chk("drain_count_L1", idx1, 128);
        chk("drain_count_L2", idx2, 128);

        // Hold occupancy at 64 with simultaneous traffic; pointers wrap.
        for (int i = 0; i < 64; i++) step(1, 0, 32'(1000 + i));
        for (int i = 0; i < 300; i++) step(1, 1, 32'(2000 + i));
        chk("steady_wrcnt", cnt1, 64);
        WE = 0; RE = 1;
        #1;
        chk("wrapped_raddr", ra1, 44);   // 428 reads so far, mod 128
        @(posedge CLOCK); #1;
        for (int i = 0; i < 63; i++) step(0, 1, 0);
        repeat (3) step(0, 0, 0);

        // Simultaneous WE/RE while empty.
        step(1, 1, 32'h55);
        chk("empty_wr_rd_underflow", udf2, 1);
        chk("empty_wr_rd_wrcnt",     cnt1, 1);
        chk("empty_wr_rd_notempty",  empty1, 0);
        step(0, 1, 0);
        repeat (3) step(0, 0, 0);

        // Reset between MEM_REN and DVLD on the latency-2 controller.
        step(1, 0, 32'hA1);
        step(1, 0, 32'hA2);
        step(0, 1, 0);
        RE = 0;
        win = 1;
        #2;
        RESET_N = 1'b0;
        #1;
        chk("midrd_EMPTY",  empty2, 1);
        chk("midrd_AEMPTY", aempty2, 1);
        chk("midrd_FULL",   full2, 0);
        chk("midrd_AFULL",  afull2, 0);
        chk("midrd_WRCNT",  cnt2, 0);
        chk("midrd_DVLD2",  dv2, 0);
        chk("midrd_DVLD1",  dv1, 0);
        repeat (2) @(posedge CLOCK);
        #1;
        RESET_N = 1'b1;
        repeat (4) step(0, 0, 0);
        win = 0;
        chk("midrd_dvld_never", seen2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_outbound_fifo_ctrl
`default_nettype wire
